// File: rtl/fip_32_cramer_solve.sv
// Cramer's-rule quotient stage for a ray/triangle intersection.
// Takes four signed Q16.16 determinants, divides the t, beta and gamma
// numerators by the system determinant with three parallel restoring
// dividers, saturates the results to Q16.16 and raises a hit flag.
// Handshake: valid/ready on both sides, one set in flight at a time.
module fip_32_cramer_solve #(
  parameter int                 FRA_BITS = 16,
  parameter logic signed [31:0] DET_EPS  = 32'sd16,
  parameter logic signed [31:0] T_MIN    = 32'sd0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_det_a,
  input  logic [31:0] i_det_t,
  input  logic [31:0] i_det_b,
  input  logic [31:0] i_det_g,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_t,
  output logic [31:0] o_beta,
  output logic [31:0] o_gamma,
  output logic        o_hit,
  output logic        o_busy
);

  // Dividend is a 33-bit magnitude shifted up by FRA_BITS; 48 bits holds it
  // and the quotient shares the same shift register, one bit per cycle.
  localparam int         W    = 48;
  localparam int         RW   = 34;
  localparam logic [5:0] LAST = 6'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  det_a_q;
  logic [31:0]  num_q   [3];   // 0: t, 1: beta, 2: gamma numerators
  logic [W-1:0] dq_q    [3];   // dividend shifting out, quotient shifting in
  logic [RW-1:0] rem_q  [3];
  logic [5:0]   cnt_q;

  logic [32:0]  mag_a;
  logic         degen;
  logic [RW:0]  div_ext;
  logic [RW:0]  rem_sh  [3];
  logic [2:0]   q_bit;
  logic [W-1:0] dq_d    [3];
  logic [RW-1:0] rem_d  [3];
  logic [31:0]  res     [3];
  logic         res_hit;
  logic signed [32:0] bg_sum;

  // Two's-complement magnitude in 33 bits so that 0x80000000 has a home.
  function automatic logic [32:0] abs33(input logic [31:0] v);
    logic [32:0] e;
    e = {v[31], v};
    return v[31] ? (33'd0 - e) : e;
  endfunction

  // Apply the sign and clamp the quotient magnitude into signed 32 bits.
  function automatic logic [31:0] sat_q(input logic [W-1:0] q, input logic neg);
    if (q == '0)
      return 32'h0000_0000;
    else if (neg)
      return (q >= 48'h0000_8000_0000) ? 32'h8000_0000 : (32'd0 - q[31:0]);
    else
      return (q > 48'h0000_7FFF_FFFF) ? 32'h7FFF_FFFF : q[31:0];
  endfunction

  // Degenerate detection on the registered system determinant.
  always_comb begin
    mag_a   = abs33(det_a_q);
    div_ext = {2'b00, mag_a};
    degen   = $signed({1'b0, mag_a}) <= $signed({{2{DET_EPS[31]}}, DET_EPS});
  end

  // One restoring-division step for each divider, plus the results the
  // final step would produce.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path; otherwise a latch is inferred.
    q_bit  = '0;
    bg_sum = '0;
    for (int i = 0; i < 3; i++) begin
      rem_sh[i] = {rem_q[i], dq_q[i][W-1]};
      q_bit[i]  = rem_sh[i] >= div_ext;
      rem_d[i]  = q_bit[i] ? RW'(rem_sh[i] - div_ext) : RW'(rem_sh[i]);
      dq_d[i]   = {dq_q[i][W-2:0], q_bit[i]};
      res[i]    = sat_q(dq_d[i], num_q[i][31] ^ det_a_q[31]);
    end
    bg_sum  = $signed({res[1][31], res[1]}) + $signed({res[2][31], res[2]});
    res_hit = !res[1][31] && !res[2][31] && (bg_sum <= 33'sh0_0001_0000) &&
              ($signed(res[0]) >= T_MIN);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous: it only takes effect at a clock edge, and
    // it overrides every other condition in the same cycle.
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_valid)        state_d = S_CHECK;
      S_CHECK: state_d = degen ? S_DONE : S_DIV;
      S_DIV:   if (cnt_q == LAST)  state_d = S_DONE;
      S_DONE:  if (i_ready)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_DONE);
    o_busy  = (state_q == S_CHECK) || (state_q == S_DIV);
  end

  // Operand capture and divider datapath.
  always_ff @(posedge i_clk) begin
    // NOTE: the datapath registers are not reset; the FSM never reads them
    // before an accepted set has overwritten them.
    if (state_q == S_IDLE && i_valid) begin
      det_a_q  <= i_det_a;
      num_q[0] <= i_det_t;
      num_q[1] <= i_det_b;
      num_q[2] <= i_det_g;
    end
    if (state_q == S_CHECK) begin
      cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        dq_q[i]  <= W'(abs33(num_q[i])) << FRA_BITS;
        rem_q[i] <= '0;
      end
    end else if (state_q == S_DIV) begin
      cnt_q <= cnt_q + 6'd1;
      for (int i = 0; i < 3; i++) begin
        dq_q[i]  <= dq_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  // Result registers: written only when entering DONE, held otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_t     <= '0;
      o_beta  <= '0;
      o_gamma <= '0;
      o_hit   <= 1'b0;
    end else if (state_q == S_CHECK && degen) begin
      o_t     <= '0;
      o_beta  <= '0;
      o_gamma <= '0;
      o_hit   <= 1'b0;
    end else if (state_q == S_DIV && cnt_q == LAST) begin
      o_t     <= res[0];
      o_beta  <= res[1];
      o_gamma <= res[2];
      o_hit   <= res_hit;
    end
  end

endmodule

// File: doc/fip_32_cramer_solve.md
FIP_32_CRAMER_SOLVE -- requirements
Module: fip_32_cramer_solve

Interface
REQ-001 SHALL have parameter FRA_BITS, default 16, meaning the number of fraction bits of all Q16.16 operands and results.
REQ-002 SHALL have parameter DET_EPS, default 32'sd16, meaning the degenerate threshold; the system is degenerate when |det_a| <= DET_EPS.
REQ-003 SHALL have parameter T_MIN, default 32'sd0, meaning the minimum accepted t for a hit.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port i_rstn  input  1  reset: synchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  upstream determinant set valid.
REQ-007 SHALL have port o_ready  output  1  block can accept a set; high only in IDLE.
REQ-008 SHALL have ports i_det_a, i_det_t, i_det_b, i_det_g  input  32 each  signed Q16.16 determinants: system, t, beta and gamma numerators.
REQ-009 SHALL have port o_valid  output  1  result valid; high only in DONE.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-011 SHALL have ports o_t, o_beta, o_gamma  output  32 each  signed Q16.16 quotients.
REQ-012 SHALL have port o_hit  output  1  the ray-triangle hit flag.
REQ-013 SHALL have port o_busy  output  1  high in CHECK or DIV.

Function
REQ-014 SHALL implement the states IDLE, CHECK, DIV and DONE.
REQ-015 SHALL, on i_valid && o_ready, register all four determinants and move to CHECK.
REQ-016 SHALL ignore i_valid outside IDLE; there is no queueing.
REQ-017 SHALL, in CHECK (one cycle), go to DONE with o_t = o_beta = o_gamma = 0 and o_hit = 0 if |det_a| <= DET_EPS; otherwise it SHALL go to DIV.
REQ-018 SHALL, in DIV, run three parallel restoring dividers that share divisor |det_a|.
- Dividend: 33-bit |num| << FRA_BITS; 48-bit working width; magnitudes are 33-bit, so 0x80000000 is handled.
- Each divider produces one quotient bit per cycle; DIV lasts exactly 48 cycles.
REQ-019 SHALL make a result negative iff sign(num) != sign(det_a) and the quotient magnitude is nonzero.
REQ-020 SHALL saturate results:
- positive magnitude > 0x7FFFFFFF -> 0x7FFFFFFF;
- negative magnitude > 0x80000000 -> 0x80000000.
REQ-021 SHALL compute o_hit = (beta >= 0) && (gamma >= 0) && (beta + gamma <= 0x00010000) && (t >= T_MIN).
- beta + gamma uses a 33-bit signed sum, with no wrap.
REQ-022 SHALL assert o_valid on the first cycle after the final DIV cycle, so that o_valid rises 50 clock edges after the acceptance edge, or 2 edges for a degenerate set.
REQ-023 SHALL, in DONE, hold all outputs stable until i_ready is sampled high, then return to IDLE.
- o_ready SHALL be high on the following cycle.
- When i_ready is high on DONE entry, the block SHALL stay in DONE for exactly one cycle.
REQ-024 SHALL return o_valid low on the cycle o_ready returns high; acceptance and result delivery never occur in the same cycle.
REQ-025 SHALL hold o_t, o_beta, o_gamma and o_hit at their last DONE values while in IDLE, CHECK and DIV; only o_valid qualifies them.

Reset
REQ-026 SHALL, when i_rstn is low at a posedge, enter IDLE from any state, including mid-DIV.
- Outputs: o_valid = 0, o_busy = 0, o_ready = 1, o_hit = 0, o_t = o_beta = o_gamma = 0.
- The in-flight set SHALL be discarded.
REQ-027 SHALL treat reset as dominant over simultaneous i_valid or i_ready.

Verification
REQ-028 SHALL verify nominal operation.
- Stimulus: det_a = 0x00020000, det_t = 0x00060000, det_b = 0x00008000, det_g = 0x00010000.
- Response: o_t = 0x00030000, o_beta = 0x00004000, o_gamma = 0x00008000, o_hit = 1; o_valid rises 50 edges after acceptance.
REQ-029 SHALL verify the degenerate case.
- Stimulus: det_a = 0x00000010.
- Response: o_valid after 2 edges, all quotients 0, o_hit = 0.
REQ-030 SHALL verify signs and boundary.
- Stimulus: det_a = 0xFFFE0000, det_t = 0x00060000, det_b = det_g = 0xFFFE0000.
- Response: o_t = 0xFFFD0000, o_beta = o_gamma = 0x00010000, o_hit = 0.
- Repeat with det_t = 0xFFFA0000, det_b = det_g = 0xFFFF0000: o_beta + o_gamma = 1.0 exactly, o_hit = 1.
REQ-031 SHALL verify saturation.
- Stimulus: det_a = 0x00000020, det_t = 0x7FFFFFFF, det_b = 0x80000000, det_g = 0.
- Response: o_t = 0x7FFFFFFF, o_beta = 0x80000000, o_gamma = 0, o_hit = 0.
REQ-032 SHALL verify backpressure.
- Stimulus: hold i_ready low for 10 cycles after o_valid, while pulsing i_valid with new data.
- Response: outputs unchanged, o_ready = 0, new data not captured; the next set is accepted only after the handshake.
REQ-033 SHALL verify reset mid-operation.
- Stimulus: assert i_rstn = 0 for one cycle, 20 cycles into DIV.
- Response: next cycle o_busy = 0, o_ready = 1, o_valid = 0, outputs 0; a following set completes normally.
